// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file and trap-state keeper:
// CSR addresses, mstatus bit positions, interrupt cause codes and FSM states.
package csr_pkg;

    // Implemented CSR addresses
    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;

    // mstatus bit positions
    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    // MPP is hardwired to machine mode
    localparam logic [31:0] MSTATUS_MPP_BITS = 32'h0000_1800;

    // Interrupt cause codes, also the bit positions in mie/mip
    localparam logic [3:0] IRQ_CODE_SOFT  = 4'd3;
    localparam logic [3:0] IRQ_CODE_TIMER = 4'd7;
    localparam logic [3:0] IRQ_CODE_EXT   = 4'd11;

    // Trap FSM states
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GUARD = 1'b1
    } trap_state_e;

    // Builds the architectural mstatus read value from the two stored bits
    function automatic logic [31:0] pack_mstatus(input logic mie, input logic mpie);
        logic [31:0] value;
        value = MSTATUS_MPP_BITS;
        value[MSTATUS_MIE]  = mie;
        value[MSTATUS_MPIE] = mpie;
        return value;
    endfunction

    // Places the three interrupt bits (soft, timer, ext) at their mie/mip positions
    function automatic logic [31:0] pack_irq_bits(input logic [2:0] bits);
        logic [31:0] value;
        value = 32'h0;
        value[IRQ_CODE_SOFT]  = bits[0];
        value[IRQ_CODE_TIMER] = bits[1];
        value[IRQ_CODE_EXT]   = bits[2];
        return value;
    endfunction

endpackage

// File: rtl/irq_sync.sv
// Two-flop synchroniser for the three asynchronous interrupt lines plus the
// fixed-priority encoder that picks the interrupt to report to the trap stage.
// Bit order of all 3-bit vectors: [0] soft, [1] timer, [2] external.
module irq_sync
    import csr_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] irq_raw,
    input  logic [2:0] irq_mask,
    output logic [2:0] irq_level,
    output logic       pending,
    output logic [3:0] code
);

    logic [2:0] stage1;
    logic [2:0] stage2;
    logic [2:0] active;

    // Two register stages so the pins settle before anything decodes them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage1 <= 3'b000;
            stage2 <= 3'b000;
        end else begin
            stage1 <= irq_raw;
            stage2 <= stage1;
        end
    end

    assign irq_level = stage2;
    assign active    = stage2 & irq_mask;

    // External beats software, software beats timer; code is 0 when idle
    always_comb begin
        pending = |active;
        code    = 4'd0;
        if (active[2]) begin
            code = IRQ_CODE_EXT;
        end else if (active[0]) begin
            code = IRQ_CODE_SOFT;
        end else if (active[1]) begin
            code = IRQ_CODE_TIMER;
        end
    end

endmodule

// File: rtl/trap_csr.sv
// Machine-mode CSR file and trap-state keeper. Accepts committed traps and
// mret from the pipeline, keeps mepc/mcause/mstatus, serves the execute
// stage's CSR port, and hands the trap stage its vector configuration, the
// global interrupt allow and the prioritised pending interrupt.
module trap_csr
    import csr_pkg::*;
#(
    parameter logic [31:0] RESET_VEC_BASE = 32'h0000_0000,
    parameter logic [31:0] HART_ID        = 32'd0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MEM_WAIT,
    input  logic [11:0] CSR_RD_ADDR,
    output logic [31:0] CSR_RD_DATA,
    input  logic        CSR_WR_EN,
    input  logic [11:0] CSR_WR_ADDR,
    input  logic [31:0] CSR_WR_DATA,
    input  logic        TRAP_EN,
    input  logic        TRAP_INT,
    input  logic [3:0]  TRAP_CODE,
    input  logic [31:0] TRAP_PC,
    input  logic        MRET_EN,
    output logic [31:0] MRET_PC,
    input  logic        IRQ_EXT,
    input  logic        IRQ_TIMER,
    input  logic        IRQ_SOFT,
    output logic [1:0]  TRAP_VEC_MODE,
    output logic [31:0] TRAP_VEC_BASE,
    output logic        INT_ALLOW,
    output logic        INT_EN,
    output logic [3:0]  INT_CODE
);

    // Architectural state
    logic        mstatus_mie;
    logic        mstatus_mpie;
    logic [2:0]  mie_bits;
    logic [31:0] mtvec;
    logic [31:0] mscratch;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [63:0] mcycle;
    trap_state_e state;

    // Synchronised interrupt lines and the encoder result
    logic [2:0]  irq_level;
    logic        irq_pending;
    logic [3:0]  irq_code;

    // Qualified event strobes; a stall freezes everything except mcycle
    logic        trap_ok;
    logic        mret_ok;
    logic        write_ok;
    logic [63:0] mcycle_next;

    assign trap_ok     = TRAP_EN && !MEM_WAIT;
    assign mret_ok     = MRET_EN && !TRAP_EN && !MEM_WAIT;
    assign write_ok    = CSR_WR_EN && !TRAP_EN && !MEM_WAIT;
    assign mcycle_next = mcycle + 64'd1;

    irq_sync u_irq_sync (
        .clk       (CLK),
        .rst_n     (RST),
        .irq_raw   ({IRQ_EXT, IRQ_TIMER, IRQ_SOFT}),
        .irq_mask  (mie_bits),
        .irq_level (irq_level),
        .pending   (irq_pending),
        .code      (irq_code)
    );

    // Trap FSM: one guard cycle after each trap hides stale registered requests
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= ST_IDLE;
        end else if (trap_ok) begin
            state <= ST_GUARD;
        end else if (state == ST_GUARD && !MEM_WAIT) begin
            state <= ST_IDLE;
        end
    end

    // mstatus MIE/MPIE: trap beats mret, mret beats a software write
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
        end else if (trap_ok) begin
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
        end else if (mret_ok) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
        end else if (write_ok && CSR_WR_ADDR == CSR_MSTATUS) begin
            mstatus_mie  <= CSR_WR_DATA[MSTATUS_MIE];
            mstatus_mpie <= CSR_WR_DATA[MSTATUS_MPIE];
        end
    end

    // Trap capture of mepc/mcause, otherwise software writes
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mepc   <= 32'h0;
            mcause <= 32'h0;
        end else if (trap_ok) begin
            mepc   <= TRAP_PC & 32'hFFFF_FFFC;
            mcause <= {TRAP_INT, 27'h0, TRAP_CODE};
        end else if (write_ok) begin
            if (CSR_WR_ADDR == CSR_MEPC) begin
                mepc <= CSR_WR_DATA & 32'hFFFF_FFFC;
            end
            if (CSR_WR_ADDR == CSR_MCAUSE) begin
                mcause <= {CSR_WR_DATA[31], 27'h0, CSR_WR_DATA[3:0]};
            end
        end
    end

    // Plain software-owned registers: mie, mtvec, mscratch
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mie_bits <= 3'b000;
            mtvec    <= {RESET_VEC_BASE[31:2], 2'b00};
            mscratch <= 32'h0;
        end else if (write_ok) begin
            if (CSR_WR_ADDR == CSR_MIE) begin
                mie_bits <= {CSR_WR_DATA[IRQ_CODE_EXT], CSR_WR_DATA[IRQ_CODE_TIMER],
                             CSR_WR_DATA[IRQ_CODE_SOFT]};
            end
            if (CSR_WR_ADDR == CSR_MTVEC) begin
                mtvec <= CSR_WR_DATA & 32'hFFFF_FFFD;
            end
            if (CSR_WR_ADDR == CSR_MSCRATCH) begin
                mscratch <= CSR_WR_DATA;
            end
        end
    end

    // Free-running cycle counter; a write replaces its half for that cycle only
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mcycle <= 64'h0;
        end else if (write_ok && CSR_WR_ADDR == CSR_MCYCLE) begin
            mcycle <= {mcycle_next[63:32], CSR_WR_DATA};
        end else if (write_ok && CSR_WR_ADDR == CSR_MCYCLEH) begin
            mcycle <= {CSR_WR_DATA, mcycle_next[31:0]};
        end else begin
            mcycle <= mcycle_next;
        end
    end

    // Read mux straight from the registers, so a same-cycle write is not visible
    always_comb begin
        CSR_RD_DATA = 32'h0;
        case (CSR_RD_ADDR)
            CSR_MSTATUS:  CSR_RD_DATA = pack_mstatus(mstatus_mie, mstatus_mpie);
            CSR_MIE:      CSR_RD_DATA = pack_irq_bits(mie_bits);
            CSR_MTVEC:    CSR_RD_DATA = mtvec;
            CSR_MSCRATCH: CSR_RD_DATA = mscratch;
            CSR_MEPC:     CSR_RD_DATA = mepc;
            CSR_MCAUSE:   CSR_RD_DATA = mcause;
            CSR_MTVAL:    CSR_RD_DATA = 32'h0;
            CSR_MIP:      CSR_RD_DATA = pack_irq_bits(irq_level);
            CSR_MCYCLE:   CSR_RD_DATA = mcycle[31:0];
            CSR_MCYCLEH:  CSR_RD_DATA = mcycle[63:32];
            CSR_MHARTID:  CSR_RD_DATA = HART_ID;
            default:      CSR_RD_DATA = 32'h0;
        endcase
    end

    assign MRET_PC       = mepc;
    assign TRAP_VEC_MODE = {1'b0, mtvec[0]};
    assign TRAP_VEC_BASE = {mtvec[31:2], 2'b00};
    assign INT_ALLOW     = mstatus_mie && (state == ST_IDLE);
    assign INT_EN        = irq_pending && (state == ST_IDLE);
    assign INT_CODE      = irq_code;

endmodule
